// File: rtl/hs_out_buffer_pkg.sv
// Shared handshake definitions for req/ack pulse-protocol buffer and fork stages.
package hs_out_buffer_pkg;

  localparam logic HS_IDLE = 1'b0;
  localparam logic HS_ACK  = 1'b1;

  // Ack is a single-cycle pulse and a producer never acks on consecutive edges,
  // so at most one word is ever in flight behind a registered request.
  localparam int HS_ACK_PULSE_CYCLES = 1;
  localparam int HS_MAX_IN_FLIGHT    = 1;

  function automatic int hs_log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/hs_out_buffer_if.sv
// Upstream (arf side) and downstream (consumer side) handshake bundle of hs_out_buffer.
interface hs_out_buffer_if #(
  parameter int data_width = 32
);
  logic                  req_l;
  logic                  ack_l;
  logic [data_width-1:0] din;
  logic                  req_r;
  logic                  ack_r;
  logic [data_width-1:0] dout;

  modport master (
    output req_l, ack_r, dout,
    input  ack_l, din, req_r
  );

  modport slave (
    input  req_l, ack_r, dout,
    output ack_l, din, req_r
  );
endinterface

// File: rtl/hs_fifo_mem.sv
// FIFO storage: synchronous write, combinational read. No reset; contents are
// meaningless whenever the owning FIFO is empty.
module hs_fifo_mem
  import hs_out_buffer_pkg::*;
#(
  parameter int data_width = 32,
  parameter int depth      = 4,
  parameter int addr_width = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [addr_width-1:0] waddr,
  input  logic [data_width-1:0] wdata,
  input  logic [addr_width-1:0] raddr,
  output logic [data_width-1:0] rdata
);

  logic [data_width-1:0] mem [depth];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/hs_out_buffer.sv
// Elastic req/ack FIFO between the arf output port and its consumer; isolates
// consumer stalls from the dataflow graph and exports throughput counters.
module hs_out_buffer
  import hs_out_buffer_pkg::*;
#(
  parameter  int data_width = 32,
  parameter  int depth      = 4,
  localparam int addr_width = hs_log2(depth)
) (
  input  logic                clk,
  input  logic                rst,
  hs_out_buffer_if.master     hs,
  output logic [addr_width:0] occupancy,
  output logic                empty,
  output logic                full,
  output logic [31:0]         count_in,
  output logic [31:0]         count_out
);

  localparam logic [addr_width:0] DEPTH_C = (addr_width+1)'(depth);

  logic [addr_width-1:0] wr_ptr, rd_ptr;
  logic [addr_width:0]   occ_next;
  logic [data_width-1:0] rd_data;
  logic                  push, pop;

  assign empty = (occupancy == '0);
  assign full  = (occupancy == DEPTH_C);

  // An ack while full is a producer protocol violation; the word is dropped.
  assign push = hs.ack_l && !full;
  // Pop looks at pre-edge occupancy, so a word pushed this edge is not visible yet.
  assign pop  = hs.req_r && !hs.ack_r && !empty;

  always_comb begin
    occ_next = occupancy;
    if (push && !pop)      occ_next = occupancy + 1'b1;
    else if (pop && !push) occ_next = occupancy - 1'b1;
  end

  hs_fifo_mem #(
    .data_width (data_width),
    .depth      (depth),
    .addr_width (addr_width)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (hs.din),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs.req_l  <= HS_IDLE;
      hs.ack_r  <= HS_IDLE;
      hs.dout   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      count_in  <= '0;
      count_out <= '0;
    end else begin
      occupancy <= occ_next;
      // Registered request: with one word in flight, full is seen before the next ack.
      hs.req_l  <= (occ_next < DEPTH_C);
      hs.ack_r  <= pop ? HS_ACK : HS_IDLE;
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        count_in <= count_in + 32'd1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        hs.dout   <= rd_data;
        count_out <= count_out + 32'd1;
      end
    end
  end

  a_no_ack_when_full: assert property (@(posedge clk) disable iff (!rst) !(hs.ack_l && full))
    else $warning("hs_out_buffer: upstream ack while full, word dropped");

endmodule
